// File: rtl/mips_core_pkg.sv
// Shared opcodes, function codes, FSM states and ALU operations for the
// multi-cycle MIPS core.
package mips_core_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    function automatic logic funct_supported(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

    function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
        alu_op_t op;
        case (funct)
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational integer ALU (ADD/SUB/AND/OR/signed SLT) with a zero flag.
// Zero latency; no handshake.
module mips_alu
    import mips_core_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = DATA_W'($signed(a) < $signed(b));
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS integer core: FETCH/DECODE/EXECUTE/WRITEBACK, 4 cycles per
// instruction; start/done run handshake, imem loads accepted only while idle/halted.
module mips_multicycle_core
    import mips_core_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_COUNT  = 32,
    parameter int IMEM_DEPTH = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_wdata,
    input  logic [$clog2(REG_COUNT)-1:0]  dbg_addr,
    output logic [DATA_W-1:0]             dbg_data,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_W-1:0]             exit,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc,
    output logic [15:0]                   retired
);

    localparam int RA_W = $clog2(REG_COUNT);
    localparam int PC_W = $clog2(IMEM_DEPTH);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic              take_q, take_d;
    logic [DATA_W-1:0] exit_q, exit_d;
    logic [15:0]       retired_q, retired_d;
    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic [DATA_W-1:0] regs_d [REG_COUNT];
    logic [31:0]       imem_q [IMEM_DEPTH];

    logic [5:0]        op, funct;
    logic [4:0]        rs_field, rt_field, rd_field;
    logic [RA_W-1:0]   rs, rt, rd, wr_addr;
    logic [DATA_W-1:0] imm_sext;
    logic              wr_en;
    logic              idle_or_halt;
    logic              imem_wr_en;
    logic [PC_W-1:0]   pc_step;
    alu_op_t           alu_op;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              unused_ir_bits;

    assign op       = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs_field = ir_q[25:21];
    assign rt_field = ir_q[20:16];
    assign rd_field = ir_q[15:11];
    assign rs       = rs_field[RA_W-1:0];
    assign rt       = rt_field[RA_W-1:0];
    assign rd       = rd_field[RA_W-1:0];
    assign imm_sext = DATA_W'($signed(ir_q[15:0]));
    assign unused_ir_bits = ^{ir_q[10:6], rs_field, rt_field, rd_field};

    assign idle_or_halt = (state_q == ST_IDLE) || (state_q == ST_HALT);
    assign imem_wr_en   = idle_or_halt && imem_we;

    // BEQ reuses the subtractor; its zero flag is the equality compare.
    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = b_q;
        if (op == OP_RTYPE) begin
            alu_op = funct_to_alu(funct);
        end else if (op == OP_BEQ) begin
            alu_op = ALU_SUB;
        end else if (op == OP_ADDI) begin
            alu_b = imm_sext;
        end
    end

    mips_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (alu_op),
        .a      (a_q),
        .b      (alu_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign wr_en   = ((op == OP_RTYPE) && funct_supported(funct)) || (op == OP_ADDI);
    assign wr_addr = (op == OP_RTYPE) ? rd : rt;
    assign pc_step = take_q ? PC_W'(imm_sext) : '0;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        take_d    = take_q;
        exit_d    = exit_q;
        retired_d = retired_q;
        regs_d    = regs_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pc_d      = '0;
                    retired_d = '0;
                end
            end
            ST_FETCH: begin
                ir_d    = imem_q[pc_q];
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                a_d     = regs_q[rs];
                b_d     = regs_q[rt];
                state_d = (op == OP_HALT) ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                alu_d   = alu_result;
                take_d  = (op == OP_BEQ) && alu_zero;
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                if (wr_en) begin
                    exit_d = alu_q;
                    if (wr_addr != '0) begin
                        regs_d[wr_addr] = alu_q;
                    end
                end
                pc_d      = pc_q + PC_W'(1) + pc_step;
                retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
                state_d   = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            take_q    <= 1'b0;
            exit_q    <= '0;
            retired_q <= '0;
            regs_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            take_q    <= take_d;
            exit_q    <= exit_d;
            retired_q <= retired_d;
            regs_q    <= regs_d;
        end
    end

    // Program storage survives reset so a loaded program can be rerun.
    always_ff @(posedge clock) begin
        if (imem_wr_en) begin
            imem_q[imem_addr] <= imem_wdata;
        end
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
    assign busy     = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                      (state_q == ST_EXECUTE) || (state_q == ST_WRITEBACK);
    assign done     = (state_q == ST_HALT);
    assign exit     = exit_q;
    assign pc       = pc_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed programs plus random straight-line/forward-branch
// programs checked against an instruction-level interpreter.
module tb_mips_multicycle_core;

    localparam int          BUDGET = 3000;
    localparam logic [31:0] W_HALT = 32'hFC00_0000;
    localparam logic [31:0] W_NOP  = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        imem_we = 1'b0;
    logic [4:0]  imem_addr = '0;
    logic [31:0] imem_wdata = '0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic        busy, done;
    logic [31:0] exit_v;
    logic [4:0]  pc;
    logic [15:0] retired;

    logic        n_start = 1'b0;
    logic        n_imem_we = 1'b0;
    logic [1:0]  n_imem_addr = '0;
    logic [31:0] n_imem_wdata = '0;
    logic [2:0]  n_dbg_addr = '0;
    logic [15:0] n_dbg_data;
    logic        n_busy, n_done;
    logic [15:0] n_exit;
    logic [1:0]  n_pc;
    logic [15:0] n_retired;

    always #5 clock = ~clock;

    mips_multicycle_core dut (
        .clock(clock), .reset(reset), .start(start), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data), .busy(busy), .done(done), .exit(exit_v), .pc(pc),
        .retired(retired)
    );

    mips_multicycle_core #(.DATA_W(16), .REG_COUNT(8), .IMEM_DEPTH(4)) dut_n (
        .clock(clock), .reset(reset), .start(n_start), .imem_we(n_imem_we),
        .imem_addr(n_imem_addr), .imem_wdata(n_imem_wdata), .dbg_addr(n_dbg_addr),
        .dbg_data(n_dbg_data), .busy(n_busy), .done(n_done), .exit(n_exit), .pc(n_pc),
        .retired(n_retired)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [31:0] m_imem [32];
    logic [31:0] m_regs [32];
    logic [31:0] m_exit;
    int          m_pc, m_retired, m_cycles;

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Instruction-level interpreter: runs from pc 0 until HALT.
    task automatic model_run();
        logic [31:0] ins, a, b, imm, val;
        logic [4:0]  wa;
        logic        wr, halted;
        int          steps;
        m_pc = 0; m_retired = 0; m_cycles = -1; halted = 1'b0; steps = 0;
        while (!halted && steps < 2000) begin
            ins = m_imem[m_pc];
            a   = m_regs[ins[25:21]];
            b   = m_regs[ins[20:16]];
            imm = {{16{ins[15]}}, ins[15:0]};
            wr = 1'b0; val = '0; wa = '0;
            if (ins[31:26] == 6'h3F) begin
                halted   = 1'b1;
                m_cycles = 4 * m_retired + 3;
            end else begin
                if (ins[31:26] == 6'h00) begin
                    wa = ins[15:11];
                    wr = 1'b1;
                    case (ins[5:0])
                        6'h20:   val = a + b;
                        6'h22:   val = a - b;
                        6'h24:   val = a & b;
                        6'h25:   val = a | b;
                        6'h2A:   val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: wr = 1'b0;
                    endcase
                end else if (ins[31:26] == 6'h08) begin
                    wa = ins[20:16]; wr = 1'b1; val = a + imm;
                end
                if (ins[31:26] == 6'h04 && a == b) m_pc = (m_pc + 1 + int'($signed(imm))) & 31;
                else m_pc = (m_pc + 1) & 31;
                if (wr) begin
                    m_exit = val;
                    if (wa != 5'd0) m_regs[wa] = val;
                end
                if (m_retired < 65535) m_retired++;
                steps++;
            end
        end
    endtask

    task automatic load_word(input logic [4:0] a, input logic [31:0] w);
        @(negedge clock);
        imem_we = 1'b1; imem_addr = a; imem_wdata = w;
        @(negedge clock);
        imem_we = 1'b0;
        m_imem[a] = w;
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    // poke_at = 0 writes together with start; >0 pokes start+imem_we mid-run.
    task automatic run_prog(input int poke_at, input logic [4:0] pa, input logic [31:0] pw,
                            output int n);
        @(negedge clock);
        start = 1'b1;
        if (poke_at == 0) begin imem_we = 1'b1; imem_addr = pa; imem_wdata = pw; end
        @(negedge clock);
        start = 1'b0; imem_we = 1'b0; n = 1;
        while (!done && n < BUDGET) begin
            if (n == poke_at) begin
                start = 1'b1; imem_we = 1'b1; imem_addr = pa; imem_wdata = pw;
            end
            @(negedge clock);
            start = 1'b0; imem_we = 1'b0; n++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        repeat (3) @(negedge clock);
        rd_reg(5'd1, v);
        cmp_cnt++; if (busy !== 1'b0)     begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        cmp_cnt++; if (done !== 1'b0)     begin err_cnt++; $display("FAIL reset_done: got %b want 0", done); end
        cmp_cnt++; if (exit_v !== 32'd0)  begin err_cnt++; $display("FAIL reset_exit: got %0h want 0", exit_v); end
        cmp_cnt++; if (pc !== 5'd0)       begin err_cnt++; $display("FAIL reset_pc: got %0d want 0", pc); end
        cmp_cnt++; if (retired !== 16'd0) begin err_cnt++; $display("FAIL reset_retired: got %0d want 0", retired); end
        cmp_cnt++; if (v !== 32'd0)       begin err_cnt++; $display("FAIL reset_r1: got %0h want 0", v); end
        cmp_cnt++; if (n_busy !== 1'b0 || n_pc !== 2'd0)
            begin err_cnt++; $display("FAIL reset_n: busy %b pc %0d want 0 0", n_busy, n_pc); end
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_exit = '0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int n; logic [31:0] v;
        load_word(5'd0, i_ins(6'h08, 5'd1, 5'd0, 16'd5));
        load_word(5'd1, i_ins(6'h08, 5'd2, 5'd0, 16'd7));
        load_word(5'd2, r_ins(6'h20, 5'd3, 5'd1, 5'd2));
        load_word(5'd3, W_HALT);
        model_run();
        run_prog(-1, 5'd0, 32'd0, n);
        rd_reg(5'd3, v);
        cmp_cnt++; if (done !== 1'b1)     begin err_cnt++; $display("FAIL basic_done: got %b want 1", done); end
        cmp_cnt++; if (n != 15)           begin err_cnt++; $display("FAIL basic_cycles: got %0d want 15", n); end
        cmp_cnt++; if (v !== 32'd12)      begin err_cnt++; $display("FAIL basic_r3: got %0h want c", v); end
        cmp_cnt++; if (exit_v !== 32'd12) begin err_cnt++; $display("FAIL basic_exit: got %0h want c", exit_v); end
        cmp_cnt++; if (retired !== 16'd3) begin err_cnt++; $display("FAIL basic_retired: got %0d want 3", retired); end
        cmp_cnt++; if (pc !== 5'd3)       begin err_cnt++; $display("FAIL basic_pc: got %0d want 3", pc); end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] v;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (5) @(negedge clock);
        cmp_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL midrun_busy_before: got %b want 1", busy); end
        reset = 1'b1;
        #1;
        cmp_cnt++; if (busy !== 1'b0 || done !== 1'b0)
            begin err_cnt++; $display("FAIL midrun_busy: got %b/%b want 0/0", busy, done); end
        cmp_cnt++; if (pc !== 5'd0)       begin err_cnt++; $display("FAIL midrun_pc: got %0d want 0", pc); end
        cmp_cnt++; if (exit_v !== 32'd0)  begin err_cnt++; $display("FAIL midrun_exit: got %0h want 0", exit_v); end
        cmp_cnt++; if (retired !== 16'd0) begin err_cnt++; $display("FAIL midrun_retired: got %0d want 0", retired); end
        rd_reg(5'd1, v);
        cmp_cnt++; if (v !== 32'd0)       begin err_cnt++; $display("FAIL midrun_r1: got %0h want 0", v); end
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_exit = '0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_alu();
        int n; logic [31:0] v;
        load_word(5'd0, i_ins(6'h08, 5'd1, 5'd0, 16'd5));
        load_word(5'd1, i_ins(6'h08, 5'd2, 5'd0, 16'd7));
        load_word(5'd2, r_ins(6'h22, 5'd4, 5'd1, 5'd2));
        load_word(5'd3, r_ins(6'h2A, 5'd5, 5'd1, 5'd2));
        load_word(5'd4, r_ins(6'h2A, 5'd7, 5'd4, 5'd1));
        load_word(5'd5, r_ins(6'h24, 5'd8, 5'd1, 5'd2));
        load_word(5'd6, r_ins(6'h25, 5'd9, 5'd1, 5'd2));
        load_word(5'd7, W_HALT);
        model_run();
        run_prog(-1, 5'd0, 32'd0, n);
        rd_reg(5'd4, v);
        cmp_cnt++; if (v !== 32'hFFFF_FFFE) begin err_cnt++; $display("FAIL alu_sub: got %0h want fffffffe", v); end
        rd_reg(5'd5, v);
        cmp_cnt++; if (v !== 32'd1) begin err_cnt++; $display("FAIL alu_slt: got %0h want 1", v); end
        rd_reg(5'd7, v);
        cmp_cnt++; if (v !== 32'd1) begin err_cnt++; $display("FAIL alu_slt_neg: got %0h want 1", v); end
        rd_reg(5'd8, v);
        cmp_cnt++; if (v !== 32'd5) begin err_cnt++; $display("FAIL alu_and: got %0h want 5", v); end
        rd_reg(5'd9, v);
        cmp_cnt++; if (v !== 32'd7) begin err_cnt++; $display("FAIL alu_or: got %0h want 7", v); end
        cmp_cnt++; if (n != 31 || retired !== 16'd7)
            begin err_cnt++; $display("FAIL alu_timing: got %0d cycles %0d retired want 31 7", n, retired); end
    endtask

    task automatic load_loop();
        load_word(5'd0, i_ins(6'h08, 5'd1, 5'd0, 16'd3));
        load_word(5'd1, i_ins(6'h08, 5'd1, 5'd1, 16'hFFFF));
        load_word(5'd2, i_ins(6'h04, 5'd0, 5'd1, 16'd1));
        load_word(5'd3, i_ins(6'h04, 5'd0, 5'd0, 16'hFFFD));
        load_word(5'd4, W_HALT);
    endtask

    task automatic test_loop();
        int n; logic [31:0] v;
        load_loop();
        model_run();
        run_prog(-1, 5'd0, 32'd0, n);
        rd_reg(5'd1, v);
        cmp_cnt++; if (v !== 32'd0)       begin err_cnt++; $display("FAIL loop_r1: got %0h want 0", v); end
        cmp_cnt++; if (retired !== 16'd9) begin err_cnt++; $display("FAIL loop_retired: got %0d want 9", retired); end
        cmp_cnt++; if (pc !== 5'd4)       begin err_cnt++; $display("FAIL loop_pc: got %0d want 4", pc); end
        cmp_cnt++; if (n != 39)           begin err_cnt++; $display("FAIL loop_cycles: got %0d want 39", n); end
    endtask

    task automatic test_r0_dbg();
        int n; logic [31:0] v;
        load_word(5'd0, i_ins(6'h08, 5'd0, 5'd0, 16'd9));
        load_word(5'd1, W_HALT);
        model_run();
        run_prog(-1, 5'd0, 32'd0, n);
        rd_reg(5'd0, v);
        cmp_cnt++; if (v !== 32'd0)      begin err_cnt++; $display("FAIL r0_dbg: got %0h want 0", v); end
        cmp_cnt++; if (exit_v !== 32'd9) begin err_cnt++; $display("FAIL r0_exit: got %0h want 9", exit_v); end
    endtask

    task automatic test_busy_ignore();
        int n; logic [31:0] v;
        load_loop();
        model_run();
        run_prog(3, 5'd2, W_HALT, n);
        rd_reg(5'd1, v);
        cmp_cnt++; if (n != m_cycles) begin err_cnt++; $display("FAIL busy_cycles: got %0d want %0d", n, m_cycles); end
        cmp_cnt++; if (retired !== 16'(m_retired))
            begin err_cnt++; $display("FAIL busy_retired: got %0d want %0d", retired, m_retired); end
        cmp_cnt++; if (v !== m_regs[1]) begin err_cnt++; $display("FAIL busy_r1: got %0h want %0h", v, m_regs[1]); end
    endtask

    task automatic test_same_cycle();
        int n; logic [31:0] v; logic [31:0] w;
        w = i_ins(6'h08, 5'd10, 5'd0, 16'd33);
        load_word(5'd0, W_NOP);
        load_word(5'd1, W_HALT);
        m_imem[0] = w;
        model_run();
        run_prog(0, 5'd0, w, n);
        rd_reg(5'd10, v);
        cmp_cnt++; if (v !== 32'd33 || exit_v !== 32'd33)
            begin err_cnt++; $display("FAIL same_cycle_r10: got %0h exit %0h want 21", v, exit_v); end
        cmp_cnt++; if (n != 7) begin err_cnt++; $display("FAIL same_cycle_cycles: got %0d want 7", n); end
    endtask

    task automatic test_random();
        logic [5:0]  fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
        logic [5:0]  junk [4] = '{6'h23, 6'h2B, 6'h0D, 6'h02};
        logic [31:0] w, v;
        int          len, kind, n;
        for (int it = 0; it < 8; it++) begin
            len = $urandom_range(6, 14);
            for (int i = 0; i < len - 1; i++) begin
                kind = $urandom_range(0, 9);
                if (kind <= 4)
                    w = r_ins(fns[$urandom_range(0, 5)], 5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                else if (kind <= 6)
                    w = i_ins(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
                else if (kind == 7)
                    w = i_ins(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                              16'($urandom_range(0, len - 2 - i)));
                else if (kind == 8)
                    w = {junk[$urandom_range(0, 3)], 26'($urandom)};
                else
                    w = i_ins(6'h08, 5'($urandom_range(1, 7)), 5'($urandom_range(0, 7)), 16'($urandom_range(0, 3)));
                load_word(5'(i), w);
            end
            load_word(5'(len - 1), {6'h3F, 26'($urandom)});
            model_run();
            run_prog(-1, 5'd0, 32'd0, n);
            cmp_cnt++; if (n != m_cycles || retired !== 16'(m_retired) || pc !== 5'(m_pc))
                begin err_cnt++; $display("FAIL rand%0d_flow: cycles %0d ret %0d pc %0d want %0d %0d %0d",
                                          it, n, retired, pc, m_cycles, m_retired, m_pc); end
            cmp_cnt++; if (exit_v !== m_exit)
                begin err_cnt++; $display("FAIL rand%0d_exit: got %0h want %0h", it, exit_v, m_exit); end
            for (int r = 0; r < 32; r++) begin
                rd_reg(5'(r), v);
                cmp_cnt++; if (v !== m_regs[r])
                    begin err_cnt++; $display("FAIL rand%0d_r%0d: got %0h want %0h", it, r, v, m_regs[r]); end
            end
        end
    endtask

    task automatic test_param();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_imem_we = 1'b1; n_imem_addr = 2'(i);
            n_imem_wdata = (i == 0) ? i_ins(6'h08, 5'd14, 5'd0, 16'hFFFF) : W_NOP;
        end
        @(negedge clock); n_imem_we = 1'b0; n_start = 1'b1;
        @(negedge clock); n_start = 1'b0;
        repeat (12) @(negedge clock);
        cmp_cnt++; if (n_pc !== 2'd3 || n_retired !== 16'd3)
            begin err_cnt++; $display("FAIL param_k3: pc %0d ret %0d want 3 3", n_pc, n_retired); end
        repeat (4) @(negedge clock);
        cmp_cnt++; if (n_pc !== 2'd0 || n_retired !== 16'd4)
            begin err_cnt++; $display("FAIL param_wrap: pc %0d ret %0d want 0 4", n_pc, n_retired); end
        repeat (20) @(negedge clock);
        cmp_cnt++; if (n_pc !== 2'd1 || n_retired !== 16'd9 || n_done !== 1'b0 || n_busy !== 1'b1)
            begin err_cnt++; $display("FAIL param_k9: pc %0d ret %0d done %b busy %b want 1 9 0 1",
                                      n_pc, n_retired, n_done, n_busy); end
        n_dbg_addr = 3'd6;
        #1;
        cmp_cnt++; if (n_dbg_data !== 16'hFFFF) begin err_cnt++; $display("FAIL param_r6: got %0h want ffff", n_dbg_data); end
        cmp_cnt++; if (n_exit !== 16'hFFFF)     begin err_cnt++; $display("FAIL param_exit: got %0h want ffff", n_exit); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_midrun();
        test_alu();
        test_loop();
        test_r0_dbg();
        test_busy_ignore();
        test_same_cycle();
        test_random();
        test_param();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multi-cycle MIPS integer core: one explicit fetch/decode/execute/writeback state machine drives the program memory, register file and ALU. Adds a start/done run handshake, a loadable instruction memory, branches, an immediate add, a halt instruction and a debug register-read port. Sits at the top of the CPU datapath; test benches and board wrappers load a program, pulse `start`, wait for `done`, then inspect results.

## Interface
- `DATA_W`, 32: datapath and register width; legal range 16..64.
- `REG_COUNT`, 32: number of architectural registers, power of two, 2..32; `RA_W = $clog2(REG_COUNT)`.
- `IMEM_DEPTH`, 32: instruction words, power of two; `PC_W = $clog2(IMEM_DEPTH)`.

- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state below.
- `start`  in  1  one-cycle run request; honoured only in IDLE or HALT.
- `imem_we`  in  1  instruction-memory write strobe; honoured only in IDLE or HALT.
- `imem_addr`  in  PC_W  instruction write address.
- `imem_wdata`  in  32  instruction word to write.
- `dbg_addr`  in  RA_W  debug register-read address.
- `dbg_data`  out  DATA_W  combinational read of register `dbg_addr` (register 0 reads 0).
- `busy`  out  1  high in FETCH/DECODE/EXECUTE/WRITEBACK.
- `done`  out  1  high while in HALT.
- `exit`  out  DATA_W  last value written to the register file.
- `pc`  out  PC_W  current program counter.
- `retired`  out  16  instructions completed since last `start`; saturates at 16'hFFFF.

## Operation
- Instruction format is fixed 32-bit MIPS: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0]. Register fields use their low RA_W bits.
- Supported: R-type (op 0) funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A (signed); ADDI op 0x08; BEQ op 0x04; HALT op 0x3F. All other op/funct: NOP (PC advances, no write, counts as retired).
- Arithmetic modulo 2^DATA_W, no overflow trap. Immediate sign-extended to DATA_W.
- Register 0 is hard-wired zero; writes to it are discarded (`exit` still updates).
- States: IDLE -> FETCH on `start`. FETCH: IR <= imem[pc]. DECODE: A <= reg[rs], B <= reg[rt]; HALT opcode -> HALT. EXECUTE: ALU result/branch compare latched. WRITEBACK: write rd (R-type) or rt (ADDI); pc <= pc+1, or pc+1+imm for taken BEQ, both modulo IMEM_DEPTH; retired++; -> FETCH.
- HALT: `done`=1; pc holds address of the HALT word; `retired` excludes it. `start` -> FETCH with pc <= 0, retired <= 0.
- `start` from IDLE also sets pc <= 0, retired <= 0. `start` while busy ignored.
- `imem_we` while busy ignored (no write). `start` and `imem_we` in the same cycle: write occurs, run starts, fetch sees the new word.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `exit`=0, `pc`=0, `retired`=0, all registers 0. Instruction memory contents are not reset.
- Non-halting instruction: exactly 4 cycles, FETCH through WRITEBACK; register write and `exit` visible the cycle after WRITEBACK.
- HALT: `done` rises 3 cycles after the FETCH of the HALT word (FETCH, DECODE, then HALT).
- `start` sampled at edge t -> `busy` high from t+1.
- Write in WRITEBACK is visible to the next instruction's DECODE (no hazards; strictly sequential).
- Reset asserted mid-instruction: all outputs return to reset values immediately, no partial write completes.

## Structure
- Package `mips_core_pkg`: opcode and funct localparams, state enum (IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT), ALU-op enum.
- Sub-module `mips_alu` (parametrised DATA_W, combinational: ADD/SUB/AND/OR/SLT, zero flag). Register file and instruction memory are inline arrays.

## Test plan
- Reset mid-run at cycle 6 -> `busy`=0, `pc`=0, `exit`=0, `retired`=0, r1 reads 0.
- Load ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; HALT; pulse `start` -> `done` after 15 cycles, r3=12, `exit`=12, `retired`=3, `pc`=3.
- SUB r4,r1,r2 with r1=5, r2=7 -> r4=0xFFFFFFFE; SLT r5,r1,r2 -> 1; ADDI r6,r0,-1 with DATA_W=16 -> 0xFFFF.
- Count-down loop: ADDI r1,r0,3; ADDI r1,r1,-1; BEQ r1,r0,+1; BEQ r0,r0,-3; HALT -> r1=0, `retired`=9.
- ADDI r0,r0,9 then dbg_addr=0 -> `dbg_data`=0, `exit`=9; `imem_we` while busy -> memory unchanged; `start` while busy -> no restart.
- IMEM_DEPTH=4, no HALT, all NOPs -> `pc` wraps 3->0, `retired` keeps counting, `done` stays 0.
